// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_pkg
// Purpose  : Shared FSM-core types and the instruction-memory width helper.
// Revision : 1.0 - initial release
// ============================================================================
package fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } load_state_e;

  // Instruction words (condition + action per state) followed by the constant bank.
  function automatic int inst_mem_width(input int state_count, input int cond_w,
                                        input int action_w, input int const_w,
                                        input int const_count);
    return state_count * (cond_w + action_w) + const_w * const_count;
  endfunction

  localparam int c_default_mem_width = inst_mem_width(16, 1, 1, 8, 6);

endpackage
`default_nettype wire

// File: rtl/prog_serializer.sv
`default_nettype none
// ============================================================================
// Module   : prog_serializer
// Purpose  : Loadable MSB-first PISO byte buffer with an in-byte bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module prog_serializer #(
  parameter int BYTE_WIDTH = 8,
  parameter int CNT_W      = $clog2(BYTE_WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [BYTE_WIDTH-1:0] data,
  input  logic [CNT_W-1:0]      nbits,
  output logic                  bit_out,
  output logic                  active,
  output logic                  last
);

  logic [BYTE_WIDTH-1:0] r_buf;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_active;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_buf    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (clear) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (load) begin
      r_buf    <= data;
      r_cnt    <= nbits;
      r_active <= (nbits != '0);
    end else if (r_active) begin
      r_buf    <= {r_buf[BYTE_WIDTH-2:0], 1'b0};
      r_cnt    <= r_cnt - CNT_W'(1);
      r_active <= (r_cnt != CNT_W'(1));
    end
  end

  assign bit_out = r_buf[BYTE_WIDTH-1];
  assign active  = r_active;
  assign last    = r_active && (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Byte-stream to MSB-first serial loader for the instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader
  import fsm_pkg::*;
#(
  parameter int MEM_WIDTH  = c_default_mem_width,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [BYTE_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  prog_enable,
  output logic                  prog_data,
  output logic                  busy,
  output logic                  done
);

  localparam int c_bl_w  = $clog2(MEM_WIDTH + 1);
  localparam int c_cnt_w = $clog2(BYTE_WIDTH + 1);

  load_state_e       r_state, w_state_next;
  logic [c_bl_w-1:0] r_bits_left;
  logic [c_bl_w-1:0] w_left_after;
  logic [c_cnt_w-1:0] w_nbits;
  logic              r_done;
  logic              w_accept, w_clear, w_start_load, w_in_ready;
  logic              w_bit, w_active, w_last;

  prog_serializer #(
    .BYTE_WIDTH (BYTE_WIDTH),
    .CNT_W      (c_cnt_w)
  ) u_serializer (
    .clock   (clock),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .load    (w_accept),
    .data    (in_data),
    .nbits   (w_nbits),
    .bit_out (w_bit),
    .active  (w_active),
    .last    (w_last)
  );

  // A gapless reload happens while the current bit is still counted in bits_left.
  assign w_left_after = (r_state == ST_SHIFT) ? (r_bits_left - c_bl_w'(1)) : r_bits_left;
  assign w_nbits      = (w_left_after >= c_bl_w'(BYTE_WIDTH)) ? c_cnt_w'(BYTE_WIDTH)
                                                              : c_cnt_w'(w_left_after);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_clear      = 1'b0;
    w_start_load = 1'b0;
    w_in_ready   = (r_state == ST_WAIT) ||
                   ((r_state == ST_SHIFT) && w_last && (r_bits_left != c_bl_w'(1)));
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_next = ST_WAIT;
          w_start_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          w_state_next = ST_IDLE;
          w_clear      = 1'b1;
        end else if (in_valid) begin
          w_state_next = ST_SHIFT;
          w_accept     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          w_state_next = ST_IDLE;
          w_clear      = 1'b1;
        end else if (w_last) begin
          if (r_bits_left == c_bl_w'(1)) begin
            w_state_next = ST_DONE;
          end else if (in_valid) begin
            w_accept = 1'b1;
          end else begin
            w_state_next = ST_WAIT;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bits_left <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == ST_DONE);
      if (w_start_load) begin
        r_bits_left <= c_bl_w'(MEM_WIDTH);
      end else if (w_active && (r_bits_left != '0)) begin
        r_bits_left <= r_bits_left - c_bl_w'(1);
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign prog_enable = w_active;
  assign prog_data   = w_bit;
  assign busy        = (r_state == ST_WAIT) || (r_state == ST_SHIFT);
  assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Scoreboard bench for prog_loader (80-bit and 12-bit images).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  localparam int MW = 80;
  localparam int BW = 8;
  localparam logic [79:0] c_image = 80'h0102030405060708090A;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, prog_enable, prog_data, busy, done;

  logic s_start = 1'b0, s_abort = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, s_en, s_dat, s_busy, s_done;

  always #5 clock = ~clock;

  prog_loader #(.MEM_WIDTH(MW), .BYTE_WIDTH(BW)) u_dut (
    .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .prog_enable(prog_enable), .prog_data(prog_data), .busy(busy), .done(done)
  );

  prog_loader #(.MEM_WIDTH(12), .BYTE_WIDTH(BW)) u_dut12 (
    .clock(clock), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .in_valid(s_valid), .in_data(s_data), .in_ready(s_ready),
    .prog_enable(s_en), .prog_data(s_dat), .busy(s_busy), .done(s_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic        exp_q[$];
  int          exp_left = 0;
  logic [79:0] mem = '0;
  logic [11:0] mem12 = '0;
  int          cnt12 = 0;
  int          en_count = 0, runs = 0, cyc = 0, last_en_cyc = 0, done_rise = 0;
  logic        prev_en = 1'b0, prev_done = 1'b0;
  logic        exp_b;

  // Instruction-memory models: shift left, insert at bit 0, on each strobe.
  always @(negedge clock) begin
    cyc++;
    if (prog_enable) begin
      en_count++;
      if (!prev_en) runs++;
      last_en_cyc = cyc;
      mem = {mem[78:0], prog_data};
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : ~prog_data;
      check_eq("serial_bit", 80'(prog_data), 80'(exp_b));
    end
    if (done && !prev_done) done_rise = cyc;
    prev_en   = prog_enable;
    prev_done = done;
    if (s_en) begin
      mem12 = {mem12[10:0], s_dat};
      cnt12++;
    end
  end

  task automatic clear_stats();
    en_count = 0; runs = 0; last_en_cyc = 0; done_rise = 0;
  endtask

  task automatic pulse_start();
    exp_left = MW;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    bit   ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      acc = in_ready && !abort;
      @(posedge clock);
      if (acc) begin
        ok = 1'b1;
        for (int k = 7; k >= 0; k--)
          if (exp_left > 0) begin
            exp_q.push_back(b[k]);
            exp_left--;
          end
      end
      #1;
    end
    check_eq("byte_accepted", 80'(ok), 80'(1));
  endtask

  task automatic send_bytes(input int n, input int gap);
    for (int i = 1; i <= n; i++) begin
      send_byte(8'(i));
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (BW + gap) @(posedge clock);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && !done; i++) @(negedge clock);
    @(posedge clock); #1;
    check_eq("done_reached", 80'(done), 80'(1));
  endtask

  task automatic check_image(input string tag, input int exp_runs);
    check_eq({tag, "_count"}, 80'(en_count), 80'(MW));
    check_eq({tag, "_runs"}, 80'(runs), 80'(exp_runs));
    check_eq({tag, "_mem"}, mem, c_image);
    check_eq({tag, "_done_lat"}, 80'(done_rise - last_en_cyc), 80'(1));
    check_eq({tag, "_busy"}, 80'(busy), 80'(0));
    check_eq({tag, "_leftover"}, 80'(exp_q.size()), 80'(0));
  endtask

  logic acc12;
  bit   got12;

  initial begin
    #2;
    check_eq("reset_outs", 80'({in_ready, prog_enable, prog_data, busy, done}), 80'(0));
    @(posedge clock); #3 rst_n = 1'b1;
    @(posedge clock); #1;
    check_eq("idle_no_ready", 80'(in_ready), 80'(0));

    // Gapless load with a start pulse landing mid-shift
    clear_stats();
    pulse_start();
    check_eq("wait_entry", 80'({in_ready, busy, done}), 80'(3'b110));
    fork
      send_bytes(10, 0);
      begin
        repeat (20) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
      end
    join
    wait_done();
    check_image("gapless", 1);

    // Restart from DONE, gapped bytes
    clear_stats();
    mem = '0;
    pulse_start();
    check_eq("restart_done_clr", 80'({done, busy}), 80'(2'b01));
    send_bytes(10, 3);
    wait_done();
    check_image("gapped", 10);

    // Abort in WAIT with a byte offered, then abort mid-shift
    pulse_start();
    send_bytes(3, 2);
    check_eq("wait_ready", 80'({in_ready, busy}), 80'(2'b11));
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h04;
    @(posedge clock); #1;
    abort = 1'b0; in_valid = 1'b0;
    check_eq("abort_wait", 80'({busy, done, prog_enable, in_ready}), 80'(0));
    @(negedge clock);
    check_eq("abort_no_accept", 80'(prog_enable), 80'(0));
    @(posedge clock); #1;
    pulse_start();
    send_byte(8'h5A);
    repeat (3) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    exp_q.delete();
    check_eq("abort_shift", 80'({prog_enable, busy, done}), 80'(0));
    clear_stats();
    pulse_start();
    send_bytes(10, 0);
    wait_done();
    check_image("post_abort", 1);

    // Asynchronous reset mid-byte
    pulse_start();
    send_byte(8'hC3);
    in_valid = 1'b0;
    @(posedge clock); #3 rst_n = 1'b0;
    #1;
    check_eq("async_reset", 80'({in_ready, prog_enable, prog_data, busy, done}), 80'(0));
    exp_q.delete();
    mem = '0;
    @(posedge clock); #2 rst_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_eq("post_reset_idle", 80'({in_ready, busy, done, prog_enable}), 80'(0));

    // 12-bit image: only the top nibble of the last byte is sent
    s_start = 1'b1;
    @(posedge clock); #1 s_start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      got12   = 1'b0;
      s_valid = 1'b1;
      s_data  = (j == 0) ? 8'hAB : 8'hCD;
      for (int i = 0; i < 50 && !got12; i++) begin
        @(negedge clock);
        acc12 = s_ready;
        @(posedge clock); #1;
        if (acc12) got12 = 1'b1;
      end
      check_eq("w12_accept", 80'(got12), 80'(1));
    end
    s_valid = 1'b0;
    for (int i = 0; i < 50 && !s_done; i++) @(negedge clock);
    @(posedge clock); #1;
    check_eq("w12_mem", 80'(mem12), 80'(12'hABC));
    check_eq("w12_count", 80'(cnt12), 80'(12));
    check_eq("w12_done", 80'({s_done, s_busy}), 80'(2'b10));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Byte-to-serial programming front end that fills the FSM instruction/constant shift register. Accepts a program image as a stream of bytes over a valid/ready handshake and drives the `prog_enable`/`prog_data` serial interface of the instruction memory, emitting exactly `MEM_WIDTH` bits per load, MSB first. Sits between the host/config port and the instruction memory. Reports `busy` and `done` so the FSM core can be held off until the image is complete.

## Interface
Parameters:
- `MEM_WIDTH`, 80: total image bits. Equals 16·2 + 6·8 for the default instruction memory.
- `BYTE_WIDTH`, 8: input word width.

Ports:
- `clock`  in  1  single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a load.
- `abort`  in  1  synchronous cancel of a load in progress.
- `in_valid`  in  1  host byte valid.
- `in_data`  in  BYTE_WIDTH  host byte.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `prog_enable`  out  1  registered; shift strobe to the instruction memory.
- `prog_data`  out  1  registered; serial bit, valid when `prog_enable`=1.
- `busy`  out  1  a load is in progress.
- `done`  out  1  sticky; the last load completed all `MEM_WIDTH` bits.

## Operation
- Image order:
  - Byte 0 bit 7 is sent first. It lands in memory bit `MEM_WIDTH-1`, because the receiver shifts left and inserts at bit 0.
  - `NBYTES = ceil(MEM_WIDTH/BYTE_WIDTH)`.
  - The final byte contributes only its top `MEM_WIDTH - (NBYTES-1)·BYTE_WIDTH` bits. Its remaining low bits are ignored.
- States: IDLE, WAIT, SHIFT, DONE.
  - IDLE: `start` → WAIT. Clear `done`. Load `bits_left` = `MEM_WIDTH`.
  - WAIT: `in_ready`=1. On `in_valid`: capture the byte into the shift buffer, set `nbits` = min(`BYTE_WIDTH`, `bits_left`), go to SHIFT.
  - SHIFT: one bit per cycle, `prog_enable`=1, buffer shifts left. On the last bit of the byte:
    - if `bits_left` reaches 0: → DONE;
    - else: `in_ready`=1 in that cycle. A handshake there goes straight to SHIFT with the new byte (gapless). No handshake → WAIT.
  - DONE: `done`=1, `busy`=0. `start` → WAIT with `done` cleared.
- `busy` = state ∈ {WAIT, SHIFT}.
- `in_ready` is combinational from the state and counters only. It never depends on `in_valid`.
- `start` while busy is ignored.
- `abort` has priority over everything in WAIT/SHIFT:
  - → IDLE, `prog_enable` drops the next cycle, `done` stays 0;
  - a byte offered in that cycle is not accepted;
  - the receiver keeps a partial image.
- `abort` in IDLE/DONE: no effect.
- Counters:
  - `bits_left` is `$clog2(MEM_WIDTH+1)` bits and decrements once per emitted bit. It never underflows.
  - The in-byte counter is `$clog2(BYTE_WIDTH+1)` bits.
- Invariant: `prog_enable` is high for exactly `MEM_WIDTH` cycles per completed load, and never outside WAIT→SHIFT→DONE.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready`, `prog_enable`, `prog_data`, `busy`, `done` all 0;
  - buffers and counters 0.
- Reset mid-load: immediate return to IDLE, outputs 0. The instruction memory shares `rst_n` and clears too.
- Byte accepted at edge N: `prog_enable`=1 with `prog_data`=bit7 during the cycle after N. Bit k is presented during the cycle after N+(7−k). The receiver samples at edges N+1..N+8.
- Back-to-back: `in_ready` is high in the cycle after N+7. With `in_valid` held, the next byte is accepted at N+8 with no bubble. Sustained rate is 1 byte per `BYTE_WIDTH` cycles.
- Single-byte latency in WAIT: 1 cycle from acceptance to first bit.
- Completion: `done` rises the cycle after the final `prog_enable` cycle. `busy` falls in the same cycle.
- `start` is sampled at edges only. WAIT is entered at the edge after `start`, and `in_ready` rises in that cycle.

## Structure
- Shared package (`fsm_pkg`):
  - the state enum;
  - function `inst_mem_width(state_count, cond_w, action_w, const_w, const_count)`, so the top level derives `MEM_WIDTH` identically for loader and memory.
- Sub-module `prog_serializer`:
  - loadable PISO byte buffer plus in-byte counter;
  - inputs: `load`, `data`, `nbits`;
  - outputs: `bit`, `active`, `last`.
  - The FSM, `bits_left` and handshake stay in `prog_loader`.

## Test plan
- MEM_WIDTH=80, 10 bytes 0x01..0x0A, `in_valid` held:
  - exactly 80 consecutive `prog_enable` cycles, no gaps;
  - a bench-side model of the instruction-memory shift register ends at 0x0102…0A;
  - `done`=1 one cycle after the last bit.
- Same image with `in_valid` gapped 3 cycles between bytes:
  - identical final memory contents;
  - `prog_enable` low during gaps;
  - total `prog_enable` count 80.
- MEM_WIDTH=12, bytes 0xAB, 0xCD:
  - 12 bits sent: A,B,C nibbles MSB first;
  - memory = 0xABC;
  - low nibble of 0xCD never emitted.
- `abort` after 3 bytes:
  - IDLE next cycle, `done`=0, `prog_enable`=0;
  - a following `start` plus 10 bytes yields a correct image and `done`=1.
- `start` pulsed during SHIFT: ignored, byte count unchanged. `start` in DONE: `done` cleared, new load begins.
- `rst_n` asserted asynchronously mid-byte: all outputs 0 without a clock edge. After release, state IDLE and `in_ready`=0 until `start`.
